fetch_hazard_controller: RTL
============================

FETCH_HAZARD_CONTROLLER -- requirements
Module: fetch_hazard_controller

Interface
REQ-001 Parameter: BOOT_CYCLES, default 2, number of post-reset cycles the PC register is held disabled.
REQ-002 Parameter: CW, default 16, width of the performance counters.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; clears all state while low.
REQ-005 RA1D, RA2D  input  4 each  source register addresses of the instruction in Decode.
REQ-006 WA3E  input  4  destination register of the instruction in Execute.
REQ-007 RegWriteE, MemtoRegE  input  1 each  Execute instruction writes a register, and that write comes from memory (load).
REQ-008 PCSrcD, PCSrcE, PCSrcM, PCSrcW  input  1 each  PC-writing instruction in D, E, M, W.
REQ-009 BranchTakenE  input  1  branch resolved taken in Execute.
REQ-010 imem_ready  input  1  instruction memory has valid data for the current PCF.
REQ-011 StallF  output  1  PC register enable (1 = PC advances, 0 = PC holds).
REQ-012 StallD  output  1  F/D pipeline register enable (1 = load, 0 = hold).
REQ-013 FlushD, FlushE  output  1 each  synchronous clear of the F/D and D/E registers (1 = clear).
REQ-014 fetch_state  output  3  current FSM state encoding.
REQ-015 stall_count, flush_count  output  CW each  saturating counts of stall cycles and flush cycles.

Function
REQ-016 FSM states and encodings: BOOT=0, RUN=1, LDSTALL=2, IMWAIT=3, PCWAIT=4; fetch_state equals the registered state.
REQ-017 BOOT: StallF=0, StallD=0, FlushD=1, FlushE=1; a boot counter counts BOOT_CYCLES cycles, then the FSM goes to RUN.
REQ-018 Load-use hazard ldhz = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D); register R0 (address 0) is not exempt.
REQ-019 pcpend = PCSrcD | PCSrcE | PCSrcM.
REQ-020 Event priority, highest first, evaluated combinationally in RUN: BranchTakenE, pcpend, ldhz, !imem_ready.
REQ-021 RUN with BranchTakenE: StallF=1, StallD=1, FlushD=1, FlushE=1 in that same cycle; the FSM stays in RUN.
REQ-022 RUN with pcpend (and no branch): StallF=0, StallD=1, FlushD=1, FlushE=0; the next state is PCWAIT.
REQ-023 PCWAIT: StallF=0, FlushD=1; the FSM leaves to RUN in the cycle after PCSrcW=1 is sampled; during the PCSrcW=1 cycle itself StallF=1 so that ResultW loads into the PC.
REQ-024 RUN with ldhz: StallF=0, StallD=0, FlushE=1, FlushD=0 for exactly one cycle; the next state is LDSTALL.
REQ-025 LDSTALL: all enables are 1 and no flush occurs; ldhz is not re-evaluated; the next state is RUN.
REQ-026 RUN or IMWAIT with !imem_ready (no higher-priority event): StallF=0, StallD=0, FlushE=1; the FSM stays in or enters IMWAIT until imem_ready=1, then returns to RUN.
REQ-027 BranchTakenE in LDSTALL or IMWAIT overrides: flush as in REQ-021, and the next state is RUN.
REQ-028 RUN with no event: StallF=1, StallD=1, FlushD=0, FlushE=0.
REQ-029 Outputs are combinational from the registered state and the current inputs; they have zero-cycle latency from hazard detection.
REQ-030 stall_count increments in every cycle with StallF=0 outside BOOT; flush_count increments in every cycle with FlushD|FlushE outside BOOT.
REQ-031 Both counters saturate at 2^CW-1 and do not wrap.

Reset
REQ-032 While rst=0: the state is BOOT, the boot counter is 0, both performance counters are 0, and the outputs are StallF=0, StallD=0, FlushD=1, FlushE=1.
REQ-033 Reset asserted mid-operation (any state) aborts immediately to BOOT with no partial counter updates.
REQ-034 After rst rises, exactly BOOT_CYCLES rising edges occur before RUN is entered.

Verification
REQ-035 Release rst at t=0; BOOT_CYCLES=2 -> fetch_state=0 for 2 cycles, then 1; StallF=1 thereafter; stall_count=0.
REQ-036 Inputs MemtoRegE=1, RegWriteE=1, WA3E=3, RA2D=3 for one cycle in RUN -> StallF=0, StallD=0, FlushE=1 for one cycle, then LDSTALL (2), then RUN; stall_count=1.
REQ-037 PCSrcD=1, then E, then M, then W on consecutive cycles -> PCWAIT held, FlushD=1 for 4 cycles, StallF=1 only in the PCSrcW cycle, then RUN; flush_count=4.
REQ-038 BranchTakenE=1 together with ldhz=1 in RUN -> FlushD=1, FlushE=1, StallF=1, and the next state is RUN (the branch wins).
REQ-039 imem_ready=0 for 3 cycles -> IMWAIT for 3 cycles with StallF=0; rst pulsed low in the 2nd cycle -> immediate BOOT, and counters read 0.
REQ-040 Force stall_count near saturation (CW=4, 20 stall cycles) -> stall_count holds at 15.

Source files
------------

// File: rtl/fetch_hazard_controller_if.sv
// fetch_hazard_controller_if: groups the pipeline hazard inputs and the fetch control outputs.
// Latency: none (wires only).
// Backpressure: none; StallF/StallD are the enables that the pipeline obeys.
// Ports: master = pipeline side (drives hazard sources, receives enables/flushes/counters),
//        slave  = controller side (the reverse).
interface fetch_hazard_controller_if #(
    parameter int CW = 16
);
    logic [3:0]    RA1D;
    logic [3:0]    RA2D;
    logic [3:0]    WA3E;
    logic          RegWriteE;
    logic          MemtoRegE;
    logic          PCSrcD;
    logic          PCSrcE;
    logic          PCSrcM;
    logic          PCSrcW;
    logic          BranchTakenE;
    logic          imem_ready;
    logic          StallF;
    logic          StallD;
    logic          FlushD;
    logic          FlushE;
    logic [2:0]    fetch_state;
    logic [CW-1:0] stall_count;
    logic [CW-1:0] flush_count;

    modport master (
        output RA1D, RA2D, WA3E, RegWriteE, MemtoRegE,
        output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, imem_ready,
        input  StallF, StallD, FlushD, FlushE, fetch_state, stall_count, flush_count
    );

    modport slave (
        input  RA1D, RA2D, WA3E, RegWriteE, MemtoRegE,
        input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, imem_ready,
        output StallF, StallD, FlushD, FlushE, fetch_state, stall_count, flush_count
    );
endinterface

// File: rtl/fetch_hazard_controller.sv
// fetch_hazard_controller: fetch/decode stall and flush control for a 5-stage pipeline.
// Latency: enables and flushes are combinational from the registered state (zero-cycle).
// Backpressure: holds PC and F/D on load-use, PC redirect and instruction-memory wait.
// Ports: clk, rst (async active-low), hz (slave side of fetch_hazard_controller_if):
//        hazard sources in; StallF/StallD enables, FlushD/FlushE clears, state and
//        saturating stall/flush cycle counters out.
module fetch_hazard_controller #(
    parameter int BOOT_CYCLES = 2,
    parameter int CW          = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    fetch_hazard_controller_if.slave  hz
);
    localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

    typedef enum logic [2:0] {
        BOOT    = 3'd0,
        RUN     = 3'd1,
        LDSTALL = 3'd2,
        IMWAIT  = 3'd3,
        PCWAIT  = 3'd4
    } fetchState_t;

    fetchState_t   stateQ;
    fetchState_t   stateNext;
    logic [BW-1:0] bootCnt;
    logic          bootDone;
    logic          ldHazard;
    logic          pcPending;
    logic          stallF;
    logic          stallD;
    logic          flushD;
    logic          flushE;
    logic [CW-1:0] stallCnt;
    logic [CW-1:0] flushCnt;

    // Leaving BOOT on the edge where the counter reads BOOT_CYCLES-1 gives exactly
    // BOOT_CYCLES rising edges between reset release and RUN.
    assign bootDone  = (int'(bootCnt) >= BOOT_CYCLES - 1);

    // R0 is deliberately not exempt: a load to R0 still stalls a dependent reader.
    assign ldHazard  = hz.MemtoRegE & hz.RegWriteE &
                       ((hz.WA3E == hz.RA1D) | (hz.WA3E == hz.RA2D));
    assign pcPending = hz.PCSrcD | hz.PCSrcE | hz.PCSrcM;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ  <= BOOT;
            bootCnt <= '0;
        end else begin
            stateQ <= stateNext;
            if (stateQ == BOOT && !bootDone) begin
                bootCnt <= bootCnt + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = stateQ;
        stallF    = 1'b1;
        stallD    = 1'b1;
        flushD    = 1'b0;
        flushE    = 1'b0;
        case (stateQ)
            BOOT: begin
                stallF = 1'b0;
                stallD = 1'b0;
                flushD = 1'b1;
                flushE = 1'b1;
                if (bootDone) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                // Priority: taken branch, pending PC write, load-use, imem wait.
                if (hz.BranchTakenE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end else if (pcPending) begin
                    stallF    = 1'b0;
                    flushD    = 1'b1;
                    stateNext = PCWAIT;
                end else if (ldHazard) begin
                    stallF    = 1'b0;
                    stallD    = 1'b0;
                    flushE    = 1'b1;
                    stateNext = LDSTALL;
                end else if (!hz.imem_ready) begin
                    stallF    = 1'b0;
                    stallD    = 1'b0;
                    flushE    = 1'b1;
                    stateNext = IMWAIT;
                end
            end
            LDSTALL: begin
                // The bubble is already in Execute; only a taken branch matters here.
                if (hz.BranchTakenE) begin
                    flushD = 1'b1;
                    flushE = 1'b1;
                end
                stateNext = RUN;
            end
            IMWAIT: begin
                if (hz.BranchTakenE) begin
                    flushD    = 1'b1;
                    flushE    = 1'b1;
                    stateNext = RUN;
                end else if (!hz.imem_ready) begin
                    stallF = 1'b0;
                    stallD = 1'b0;
                    flushE = 1'b1;
                end else begin
                    stateNext = RUN;
                end
            end
            PCWAIT: begin
                flushD = 1'b1;
                // PC is enabled in the write-back cycle so ResultW lands in the PC.
                if (hz.PCSrcW) begin
                    stateNext = RUN;
                end else begin
                    stallF = 1'b0;
                end
            end
            default: begin
                stallF    = 1'b0;
                stallD    = 1'b0;
                flushD    = 1'b1;
                flushE    = 1'b1;
                stateNext = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else if (stateQ != BOOT) begin
            if (!stallF && stallCnt != {CW{1'b1}}) begin
                stallCnt <= stallCnt + 1'b1;
            end
            if ((flushD | flushE) && flushCnt != {CW{1'b1}}) begin
                flushCnt <= flushCnt + 1'b1;
            end
        end
    end

    assign hz.StallF      = stallF;
    assign hz.StallD      = stallD;
    assign hz.FlushD      = flushD;
    assign hz.FlushE      = flushE;
    assign hz.fetch_state = stateQ;
    assign hz.stall_count = stallCnt;
    assign hz.flush_count = flushCnt;
endmodule
